// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared types, sizes and round-robin pick for the arbiter slice
package mux4_rr_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int NCH = 4;
  localparam int DW = 4;
  localparam int MAX_BURST_DEF = 4;
  // First asserted request after last, with wrap; the descending loop leaves the nearest hit.
  function automatic logic [1:0] rr_pick(input logic [NCH-1:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = NCH; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// mux_4_1_4bit: shared 4:1 data-path mux
module mux_4_1_4bit
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [1:0]    sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] y
);
  always_comb y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin, burst-bounded arbiter sharing one 4:1 data mux
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic [DW-1:0]   data_a,
  input  logic [DW-1:0]   data_b,
  input  logic [DW-1:0]   data_c,
  input  logic [DW-1:0]   data_d,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [NCH-1:0]  gnt,
  output logic [1:0]      sel,
  output logic [NCH-1:0]  ack,
  output logic            busy
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  state_t state, state_n;
  logic [1:0] sel_n, last, last_n, pick;
  logic [3:0] beat_cnt, cnt_n;
  logic [NCH-1:0] gnt_n;
  logic accept, done;
  mux_4_1_4bit u_mux (
    .sel(sel),
    .a(data_a),
    .b(data_b),
    .c(data_c),
    .d(data_d),
    .y(out_data)
  );
  // out_valid is masked during reset so a mid-burst reset never acks a beat.
  always_comb begin
    pick = rr_pick(req, last);
    busy = state == GRANT;
    out_valid = rst_n & busy & req[sel];
    accept = out_valid & out_ready;
    ack = accept ? 4'b0001 << sel : '0;
    done = !req[sel] || (accept && beat_cnt + 4'd1 == MB);
    state_n = state;
    sel_n = sel;
    gnt_n = gnt;
    last_n = last;
    cnt_n = beat_cnt;
    if (!busy && |req) begin
      state_n = GRANT;
      sel_n = pick;
      gnt_n = 4'b0001 << pick;
      cnt_n = '0;
    end else if (busy) begin
      cnt_n = beat_cnt + 4'(accept);
      if (done) begin
        state_n = IDLE;
        gnt_n = '0;
        last_n = sel;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      gnt <= '0;
      last <= 2'd3;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      gnt <= gnt_n;
      last <= last_n;
      beat_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: cycle-by-cycle directed vector table for the round-robin arbiter
module tb_mux4_rr_arbiter;
  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [3:0] ack;
    logic       busy;
    logic [3:0] data;
  } vec_t;
  vec_t v[$];
  logic clk = 0;
  logic rst_n;
  logic [3:0] req, data_a, data_b, data_c, data_d, out_data, gnt, ack;
  logic out_ready, out_valid, busy;
  logic [1:0] sel;
  int passed = 0;
  int total = 0;
  mux4_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data_a(data_a),
    .data_b(data_b),
    .data_c(data_c),
    .data_d(data_d),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .gnt(gnt),
    .sel(sel),
    .ack(ack),
    .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic void add(logic r, logic [3:0] q, logic y, logic [3:0] g, logic [1:0] s,
                              logic vl, logic [3:0] a, logic b, logic [3:0] d);
    v.push_back('{r, q, y, g, s, vl, a, b, d});
  endfunction
  task automatic chk(string name, int row, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask
  initial begin
    // reset held two cycles with all requests up; priority starts at channel 0
    add(0, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 4'h5);
    add(0, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 4'h5);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 4'h5);
    add(1, 4'hF, 0, 4'h1, 0, 1, 4'h0, 1, 4'h5);
    // fairness: 0,1,2,3,0 with 4 beats and one bubble each
    for (int i = 0; i < 4; i++) add(1, 4'hF, 1, 4'h1, 0, 1, 4'h1, 1, 4'h5);
    add(1, 4'hF, 1, 4'h0, 0, 0, 4'h0, 0, 4'h5);
    for (int i = 0; i < 4; i++) add(1, 4'hF, 1, 4'h2, 1, 1, 4'h2, 1, 4'h6);
    add(1, 4'hF, 1, 4'h0, 1, 0, 4'h0, 0, 4'h6);
    for (int i = 0; i < 4; i++) add(1, 4'hF, 1, 4'h4, 2, 1, 4'h4, 1, 4'hA);
    add(1, 4'hF, 1, 4'h0, 2, 0, 4'h0, 0, 4'hA);
    for (int i = 0; i < 4; i++) add(1, 4'hF, 1, 4'h8, 3, 1, 4'h8, 1, 4'hC);
    add(1, 4'hF, 1, 4'h0, 3, 0, 4'h0, 0, 4'hC);
    add(1, 4'hF, 1, 4'h1, 0, 1, 4'h1, 1, 4'h5);
    // reset mid-burst: no ack in the reset cycle
    add(0, 4'h4, 1, 4'h1, 0, 0, 4'h0, 1, 4'h5);
    // single channel 2: exactly 4 beats, bubble, re-grant, then abandon
    add(1, 4'h4, 1, 4'h0, 0, 0, 4'h0, 0, 4'h5);
    for (int i = 0; i < 4; i++) add(1, 4'h4, 1, 4'h4, 2, 1, 4'h4, 1, 4'hA);
    add(1, 4'h4, 1, 4'h0, 2, 0, 4'h0, 0, 4'hA);
    add(1, 4'h4, 1, 4'h4, 2, 1, 4'h4, 1, 4'hA);
    add(1, 4'h0, 1, 4'h4, 2, 0, 4'h0, 1, 4'hA);
    add(1, 4'h2, 0, 4'h0, 2, 0, 4'h0, 0, 4'hA);
    // backpressure on channel 1: ready 1,0,0,1 then two more beats to the limit
    add(1, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1, 4'h6);
    add(1, 4'h2, 0, 4'h2, 1, 1, 4'h0, 1, 4'h6);
    add(1, 4'h2, 0, 4'h2, 1, 1, 4'h0, 1, 4'h6);
    add(1, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1, 4'h6);
    add(1, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1, 4'h6);
    add(1, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1, 4'h6);
    add(1, 4'h8, 0, 4'h0, 1, 0, 4'h0, 0, 4'h6);
    // abandon on channel 3 with ready high and valid low: no ack
    add(1, 4'h8, 0, 4'h8, 3, 1, 4'h0, 1, 4'hC);
    add(1, 4'h1, 1, 4'h8, 3, 0, 4'h0, 1, 4'hC);
    add(1, 4'h1, 1, 4'h0, 3, 0, 4'h0, 0, 4'hC);
    add(1, 4'h1, 1, 4'h1, 0, 1, 4'h1, 1, 4'h5);
    // channel 1 request raised during channel 0's grant is served next
    add(1, 4'h3, 0, 4'h1, 0, 1, 4'h0, 1, 4'h5);
    add(1, 4'h2, 0, 4'h1, 0, 0, 4'h0, 1, 4'h5);
    add(1, 4'h2, 1, 4'h0, 0, 0, 4'h0, 0, 4'h5);
    add(1, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1, 4'h6);
    add(1, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1, 4'h6);
    // reset after 2 beats on channel 1, then a full fresh 4-beat burst
    add(0, 4'h2, 1, 4'h2, 1, 0, 4'h0, 1, 4'h6);
    add(1, 4'h2, 0, 4'h0, 0, 0, 4'h0, 0, 4'h5);
    for (int i = 0; i < 4; i++) add(1, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1, 4'h6);
    add(1, 4'h0, 0, 4'h0, 1, 0, 4'h0, 0, 4'h6);
    data_a = 4'h5;
    data_b = 4'h6;
    data_c = 4'hA;
    data_d = 4'hC;
    rst_n = 0;
    req = 4'hF;
    out_ready = 0;
    @(posedge clk);
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      rst_n = v[i].rst_n;
      req = v[i].req;
      out_ready = v[i].rdy;
      #2;
      chk("gnt", i, gnt, v[i].gnt);
      chk("sel", i, {2'b00, sel}, {2'b00, v[i].sel});
      chk("out_valid", i, {3'b000, out_valid}, {3'b000, v[i].vld});
      chk("ack", i, ack, v[i].ack);
      chk("busy", i, {3'b000, busy}, {3'b000, v[i].busy});
      chk("out_data", i, out_data, v[i].data);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
